// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: sequences PLL reset, lock qualification and downstream reset release
module pll_reset_ctrl #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT = 27000,
   parameter int STABLE_CYCLES = 2700
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       pll_lock,
   input  logic       soft_reinit,
   output logic       pll_reset,
   output logic       rst_out,
   output logic       ready,
   output logic [1:0] state,
   output logic [7:0] retry_cnt,
   output logic [7:0] loss_cnt
);
   localparam int M1 = PLL_RST_CYCLES > LOCK_TIMEOUT ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAXP = M1 > STABLE_CYCLES ? M1 : STABLE_CYCLES;
   localparam int CW = MAXP > 1 ? $clog2(MAXP) : 1;
   localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] ST_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [1:0] RESET_PLL = 2'd0;
   localparam logic [1:0] WAIT_LOCK = 2'd1;
   localparam logic [1:0] STABLE = 2'd2;
   localparam logic [1:0] RUN = 2'd3;
   logic          lock_m, lock_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    nxt;
   logic [7:0]    retry_n, loss_n;
   always_comb begin
      nxt = state;
      cnt_n = cnt + 1'b1;
      retry_n = retry_cnt;
      loss_n = loss_cnt;
      if (soft_reinit)
         nxt = RESET_PLL;
      else
         case (state)
            RESET_PLL: nxt = cnt == RST_LAST ? WAIT_LOCK : RESET_PLL;
            WAIT_LOCK:
               if (lock_s)
                  nxt = STABLE;
               else if (cnt == TO_LAST) begin
                  nxt = RESET_PLL;
                  retry_n = retry_cnt + {7'd0, retry_cnt != 8'hFF};
               end
            STABLE: nxt = !lock_s ? WAIT_LOCK : cnt == ST_LAST ? RUN : STABLE;
            default:
               if (!lock_s) begin
                  nxt = RESET_PLL;
                  loss_n = loss_cnt + {7'd0, loss_cnt != 8'hFF};
               end else
                  cnt_n = cnt;
         endcase
      // a soft re-init from RESET_PLL restarts the pulse even though the state code is unchanged
      if (nxt != state || soft_reinit)
         cnt_n = '0;
   end
   always_ff @(posedge sys_clk)
      if (rst) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
         state <= RESET_PLL;
         cnt <= '0;
         pll_reset <= 1'b1;
         rst_out <= 1'b1;
         ready <= 1'b0;
         retry_cnt <= 8'd0;
         loss_cnt <= 8'd0;
      end else begin
         lock_m <= pll_lock;
         lock_s <= lock_m;
         state <= nxt;
         cnt <= cnt_n;
         pll_reset <= nxt == RESET_PLL;
         rst_out <= nxt != RUN;
         ready <= nxt == RUN;
         retry_cnt <= retry_n;
         loss_cnt <= loss_n;
      end
endmodule
